// File: rtl/mul_nnbit_s01_abs_itera_if.sv
// Request/response bundle for the iterative absolute-value multiplier.
// Request side: i_valid/i_signed/i_num_x/i_num_y. Response side: o_ready/o_res/o_valid.
interface mul_nnbit_s01_abs_itera_if #(
    parameter int DATA_WIDTH = 8
);
    // Valid/ready: a request transfers on a rising edge where i_valid and o_ready
    // are both high. o_valid is a single-cycle pulse and is never back-pressured.
    logic                      i_valid;
    logic                      i_signed;
    logic [DATA_WIDTH-1:0]     i_num_x;
    logic [DATA_WIDTH-1:0]     i_num_y;
    logic                      o_ready;
    logic [2*DATA_WIDTH-1:0]   o_res;
    logic                      o_valid;

    modport master (
        output i_valid,
        output i_signed,
        output i_num_x,
        output i_num_y,
        input  o_ready,
        input  o_res,
        input  o_valid
    );

    modport slave (
        input  i_valid,
        input  i_signed,
        input  i_num_x,
        input  i_num_y,
        output o_ready,
        output o_res,
        output o_valid
    );
endinterface

// File: rtl/mul_nnbit_s01_abs_itera.sv
// Radix-2 shift-add multiplier on operand magnitudes; the sign is reapplied to the
// final sum. Fixed latency of DATA_WIDTH iterations, full 2*DATA_WIDTH-bit product.
module mul_nnbit_s01_abs_itera #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    mul_nnbit_s01_abs_itera_if.slave bus,
    output logic [1:0]             o_dbg_state
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplr_q,  mplr_d;
    logic [PW-1:0]   acc_q,   acc_d;
    logic            neg_q,   neg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [PW-1:0]   res_q,   res_d;

    logic [W-1:0]    x_abs;
    logic [W-1:0]    y_abs;
    logic [PW-1:0]   acc_next;

    // The most-negative input negates to itself, which read as unsigned is its magnitude.
    always_comb begin
        x_abs = (bus.i_signed & bus.i_num_x[W-1]) ? -bus.i_num_x : bus.i_num_x;
        y_abs = (bus.i_signed & bus.i_num_y[W-1]) ? -bus.i_num_y : bus.i_num_y;
    end

    always_comb begin
        acc_next = acc_q + (mplr_q[0] ? mcand_q : {PW{1'b0}});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    mcand_d = {{W{1'b0}}, x_abs};
                    mplr_d  = y_abs;
                    neg_d   = bus.i_signed & (bus.i_num_x[W-1] ^ bus.i_num_y[W-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_next;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // No early exit: every operation runs all DATA_WIDTH iterations.
                if (cnt_q == LAST_CNT) begin
                    res_d   = neg_q ? -acc_next : acc_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_res   = res_q;
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_mul_nnbit_s01_abs_itera.sv
// Directed bench for the iterative absolute-value multiplier, DATA_WIDTH = 8.
// Expected products are hand-computed constants.
module tb_mul_nnbit_s01_abs_itera;
    localparam int DW = 8;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;
    logic [15:0] last_res;
    logic [15:0] exp_q[$];

    mul_nnbit_s01_abs_itera_if #(.DATA_WIDTH(DW)) bus ();

    mul_nnbit_s01_abs_itera #(.DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request and checks latency, hold of the previous result, and the product.
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [15:0] exp_res);
        int lat;
        bit got;
        @(negedge clk);
        check({tag, "_ready"}, bus.o_ready, 1);
        bus.i_valid  = 1'b1;
        bus.i_signed = s;
        bus.i_num_x  = x;
        bus.i_num_y  = y;
        @(posedge clk);
        lat = 0;
        got = 0;
        for (int n = 0; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (n == 0) bus.i_valid = 1'b0;
            if (n == 4) begin
                check({tag, "_hold"}, bus.o_res, last_res);
                check({tag, "_busy"}, bus.o_ready, 0);
                check({tag, "_dbg"}, dbg_state, 2'd1);
            end
            if (bus.o_valid) begin
                got = 1;
                lat = n;
            end
        end
        check({tag, "_seen"}, got, 1);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_res"}, bus.o_res, exp_res);
        last_res = exp_res;
        @(negedge clk);
        check({tag, "_pulse"}, bus.o_valid, 0);
        check({tag, "_rdy_back"}, bus.o_ready, 1);
    endtask

    initial begin
        int accepts[$];
        int ready_low;
        int results;
        checks    = 0;
        failures  = 0;
        last_res  = 16'h0000;
        bus.i_valid  = 1'b0;
        bus.i_signed = 1'b0;
        bus.i_num_x  = '0;
        bus.i_num_y  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_res", bus.o_res, 16'h0000);
        check("rst_state", dbg_state, 2'd0);

        run_op("s_95x1d", 8'h95, 8'h1D, 1'b1, 16'hF3E1);
        run_op("u_95x1d", 8'h95, 8'h1D, 1'b0, 16'h10E1);
        run_op("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("s_80x7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run_op("s_ffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("s_00x95", 8'h00, 8'h95, 1'b1, 16'h0000);
        run_op("s_07xfd", 8'h07, 8'hFD, 1'b1, 16'hFFEB);
        run_op("u_0cx0a", 8'h0C, 8'h0A, 1'b0, 16'h0078);

        // Held valid: operands change while busy and must only matter at the next accept.
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_signed = 1'b0;
        bus.i_num_x  = 8'h03;
        bus.i_num_y  = 8'h05;
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h003F);
        ready_low = 0;
        results   = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.o_ready && bus.i_valid) accepts.push_back(c);
            if (!bus.o_ready && accepts.size() == 1) ready_low++;
            if (bus.o_valid) begin
                results++;
                if (exp_q.size() > 0) check("hs_res", bus.o_res, exp_q.pop_front());
                else check("hs_extra_result", 1, 0);
            end
            if (c == 1) begin
                bus.i_num_x = 8'h07;
                bus.i_num_y = 8'h09;
            end
            if (c == 5) bus.i_num_x = 8'hAA;
            if (c == 9) bus.i_num_x = 8'h07;
            if (accepts.size() == 2 && c > accepts[1]) bus.i_valid = 1'b0;
        end
        check("hs_accepts", accepts.size(), 2);
        if (accepts.size() == 2) check("hs_spacing", accepts[1] - accepts[0], 10);
        check("hs_ready_low", ready_low, 9);
        check("hs_results", results, 2);
        check("hs_queue_empty", exp_q.size(), 0);
        last_res = 16'h003F;
        repeat (2) @(negedge clk);

        // Reset mid-operation: abort once four iterations have completed.
        bus.i_valid  = 1'b1;
        bus.i_signed = 1'b1;
        bus.i_num_x  = 8'h95;
        bus.i_num_y  = 8'h1D;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", bus.o_ready, 1);
        check("abort_res", bus.o_res, 16'h0000);
        check("abort_valid", bus.o_valid, 0);
        begin
            int spurious;
            spurious = 0;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (bus.o_valid) spurious++;
            end
            check("abort_no_valid", spurious, 0);
        end
        last_res = 16'h0000;
        run_op("post_abort", 8'h95, 8'h1D, 1'b1, 16'hF3E1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
